// File: rtl/seq_pkg.sv
// Shared opcode encodings and FSM state type for the program sequencer.
package seq_pkg;

    localparam logic [3:0] OP_HLT  = 4'hA;
    localparam logic [3:0] OP_RET  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_CALL = 4'hF;

    localparam int INS_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for CALL/RET; push and pop are never requested together.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    // One extra count bit distinguishes full from empty; DEPTH is a power of two.
    logic [PW:0]      cnt_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    top_idx;

    assign top_idx = cnt_q[PW-1:0] - PW'(1);
    assign dout    = mem_q[top_idx];
    assign full    = cnt_q[PW];
    assign empty   = (cnt_q == '0);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[cnt_q[PW-1:0]] <= din;
            cnt_q                <= cnt_q + (PW+1)'(1);
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/execute controller: owns the program counter and instruction register,
// resolves control flow through a hardware return stack, and qualifies datapath writes.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [INS_W-1:0]  Ins,
    input  logic              AccuZero,
    input  logic              Carry,
    input  logic              run,
    input  logic              step_req,
    output logic [ADDR_W-1:0] Addr,
    output logic [INS_W-1:0]  IR,
    output logic              ExecEn,
    output logic              step_ack,
    output logic              Halted,
    output logic              StackErr,
    output seq_state_t        dbg_state_o
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INS_W-1:0]  ir_q, ir_d;
    logic              step_q, step_d;
    logic              err_q, err_d;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic              halt_now;

    logic              stk_push, stk_pop;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_full, stk_empty;

    assign opcode = ir_q[12:9];
    assign target = ir_q[ADDR_W-1:0];
    assign pc_inc = pc_q + ADDR_W'(1);

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk    (clk),
        .nReset (nReset),
        .push   (stk_push),
        .pop    (stk_pop),
        .din    (pc_inc),
        .dout   (stk_dout),
        .full   (stk_full),
        .empty  (stk_empty)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    // Step handshake: step_req is a one-cycle request honoured only in IDLE (never queued);
    // step_ack answers it with a one-cycle pulse in the EXEC cycle of the stepped instruction.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        step_d   = step_q;
        err_d    = err_q;
        halt_now = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        step_ack = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else if (step_req) begin
                    state_d = ST_FETCH;
                    step_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                ir_d    = Ins;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_JMP: pc_d = target;
                    OP_JZ:  pc_d = AccuZero ? target : pc_inc;
                    OP_JC:  pc_d = Carry ? target : pc_inc;
                    OP_CALL: begin
                        if (stk_full) begin
                            err_d    = 1'b1;
                            halt_now = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = target;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            err_d    = 1'b1;
                            halt_now = 1'b1;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_dout;
                        end
                    end
                    OP_HLT:  halt_now = 1'b1;
                    default: pc_d = pc_inc;
                endcase

                if (step_q) begin
                    step_ack = 1'b1;
                    step_d   = 1'b0;
                end

                if (halt_now) begin
                    state_d = ST_HALT;
                end else if (step_q) begin
                    state_d = ST_IDLE;
                end else if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Derived straight from the state register so a reset mid-EXEC drops it immediately.
    assign ExecEn      = (state_q == ST_EXEC);
    assign Halted      = (state_q == ST_HALT);
    assign Addr        = pc_q;
    assign IR          = ir_q;
    assign StackErr    = err_q;
    assign dbg_state_o = state_q;

endmodule
